i2c_reg_slave: RTL

I2C write-only responder with an internal register file, clocked by the system clock `iCLK` and oversampling the bus. It accepts `[SLAVE_ADDR, SUB_ADDR, DATA...]` transfers as issued by our I2C configuration master: 7-bit device address plus write bit, 8-bit sub-address, then one or more data bytes with auto-increment. It drives ACK/NACK on `I2C_SDAT` and exposes each accepted write as a one-cycle strobe. It is the bench/loopback target for the codec/decoder configuration path, and the slave side in board-to-board configuration links.

---
 rtl/i2c_reg_slave.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave
//   Write-only I2C responder backed by an internal byte register file.
//   Accepts [DEV_ADDR+W, SUB_ADDR, DATA...] transfers with sub-address
//   auto-increment, drives ACK/NACK on the open-drain SDA line, and reports
//   each accepted byte as a one-cycle write strobe. SCL/SDA are oversampled
//   on iCLK, which must run at least 16x the SCL frequency.
//
// Ports
//   iCLK, iRST_N : system clock, asynchronous active-low reset
//   I2C_SCLK     : bus clock from the master
//   I2C_SDAT     : open-drain data (driven only to 0 or z)
//   iRD_ADDR     : register-file read address
//   oRD_DATA     : registered read data, one cycle after iRD_ADDR
//   oWR_EN       : one-cycle strobe per accepted data byte
//   oWR_ADDR     : address of the accepted byte, valid with oWR_EN
//   oWR_DATA     : accepted byte, valid with oWR_EN
//   oBUSY        : high from an addressed START until STOP or abort
//   oDONE        : one-cycle pulse after STOP if any byte was written
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         ADDR_W   = 6
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              I2C_SCLK,
  inout  wire               I2C_SDAT,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic [7:0]        oRD_DATA,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [7:0]        oWR_DATA,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int REG_DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_SUB,
    ST_ACK_SUB,
    ST_DATA,
    ST_ACK_DATA,
    ST_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer plus one delay flop per line.
  // Both lines see identical latency, so their relative ordering is kept.
  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  // ---------------------------------------------------------------------------
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= I2C_SCLK;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= I2C_SDAT;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  // START/STOP require SCL high on both sides of the SDA transition.
  assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

  // ---------------------------------------------------------------------------
  // Protocol FSM and register file
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [ADDR_W:0]   ptr;        // one bit wider than the address: no wrap
  logic              ack_phase;  // 0: waiting to start ACK, 1: ACK driven
  logic              sda_oe;
  logic              wrote;      // a byte was written since the last START
  logic [7:0]        regfile [REG_DEPTH];

  logic [7:0]        rx_byte;
  logic [ADDR_W:0]   sub_ext;

  // Byte as it stands including the bit being sampled this cycle.
  assign rx_byte = {shift[6:0], sda_s2};
  // Only loaded into ptr after the range check, so truncation is harmless.
  assign sub_ext = (ADDR_W + 1)'(rx_byte);

  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  // NOTE: the register file is cleared by reset because the block's contract
  // says reset leaves every entry at 8'h00; storage without that requirement
  // would normally stay unreset so it can map onto RAM.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      wrote     <= 1'b0;
      oWR_EN    <= 1'b0;
      oWR_ADDR  <= '0;
      oWR_DATA  <= '0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regfile[i] <= 8'h00;
    end else begin
      oWR_EN <= 1'b0;
      oDONE  <= 1'b0;

      if (stop_det) begin
        // STOP from any state; a partial byte is simply dropped.
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        oBUSY     <= 1'b0;
        oDONE     <= wrote;
        wrote     <= 1'b0;
      end else if (start_det) begin
        // START or repeated START from any state.
        state     <= ST_DEV;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        oBUSY     <= 1'b1;
        wrote     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_IGNORE: ;

          ST_DEV, ST_SUB, ST_DATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b0;
                if (state == ST_DEV) begin
                  if (rx_byte == {DEV_ADDR, 1'b0}) begin
                    state <= ST_ACK_DEV;
                  end else begin
                    state <= ST_IGNORE;
                    oBUSY <= 1'b0;
                  end
                end else if (state == ST_SUB) begin
                  if (int'(rx_byte) < REG_DEPTH) begin
                    ptr   <= sub_ext;
                    state <= ST_ACK_SUB;
                  end else begin
                    state <= ST_IGNORE;
                    oBUSY <= 1'b0;
                  end
                end else begin
                  // ptr MSB set means ptr == REG_DEPTH: past the last entry.
                  if (!ptr[ADDR_W]) begin
                    state <= ST_ACK_DATA;
                  end else begin
                    state <= ST_IGNORE;
                    oBUSY <= 1'b0;
                  end
                end
              end
            end
          end

          ST_ACK_DEV, ST_ACK_SUB, ST_ACK_DATA: begin
            // First SCL fall after the 8th bit starts the ACK, the next ends it.
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= 1'b1;
                if (state == ST_ACK_DATA) begin
                  regfile[ptr[ADDR_W-1:0]] <= shift;
                  oWR_EN   <= 1'b1;
                  oWR_ADDR <= ptr[ADDR_W-1:0];
                  oWR_DATA <= shift;
                  ptr      <= ptr + 1'b1;
                  wrote    <= 1'b1;
                end
              end else begin
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                state     <= (state == ST_ACK_DEV) ? ST_SUB : ST_DATA;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Registered read port; a same-cycle write is seen on the following read.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) oRD_DATA <= 8'h00;
    else         oRD_DATA <= regfile[iRD_ADDR];
  end

endmodule
